// File: rtl/i2c_reg_bridge.sv
// Register-file bridge behind an I2C target front end: toggle-handshake events
// from the I2C domain set a register pointer, write bytes, and step through reads.
module i2c_reg_bridge #(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int        PW        = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  addr_toggle,
    input  logic                  rw,
    input  logic                  rx_toggle,
    input  logic [7:0]            rx_data,
    input  logic                  tx_toggle,
    output logic [7:0]            tx_data,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [PW-1:0]         wr_addr,
    output logic [PW-1:0]         ptr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_PTR = 2'd1,
        WRITE   = 2'd2,
        READ    = 2'd3
    } state_t;

    // Bit order in the toggle vectors: [0] addr, [1] rx, [2] tx.
    logic [2:0] tog_in;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] prev_q, prev_d;
    logic [1:0] rw_sync_q, rw_sync_d;
    logic [2:0] evt;
    logic       addr_evt, rx_evt, tx_evt;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];
    logic [7:0]    tx_data_q, tx_data_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;

    assign tog_in   = {tx_toggle, rx_toggle, addr_toggle};
    assign evt      = sync2_q ^ prev_q;
    assign addr_evt = evt[0];
    assign rx_evt   = evt[1];
    assign tx_evt   = evt[2];

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path can leave a latch behind.
        sync1_d     = tog_in;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        rw_sync_d   = {rw_sync_q[0], rw};
        state_d     = state_q;
        ptr_d       = ptr_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        tx_data_d   = regs_q[ptr_q];

        // A fresh address phase always restarts the transfer and swallows any same-cycle data event.
        if (addr_evt) begin
            state_d = rw_sync_q[1] ? READ : GET_PTR;
        end else begin
            unique case (state_q)
                IDLE: ;
                GET_PTR: begin
                    if (rx_evt) begin
                        ptr_d   = rx_data[PW-1:0];
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (rx_evt) begin
                        regs_d[ptr_q] = rx_data;
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = ptr_q;
                        ptr_d         = ptr_q + 1'b1;
                    end
                end
                READ: begin
                    if (tx_evt) ptr_d = ptr_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            rw_sync_q   <= '0;
            state_q     <= IDLE;
            ptr_q       <= '0;
            // NOTE: the register file is visible on regs_flat and must come up defined, so every entry is reset here.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
            tx_data_q   <= RESET_VAL;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            rw_sync_q   <= rw_sync_d;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            tx_data_q   <= tx_data_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = regs_q[k];
    end

    assign tx_data   = tx_data_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Self-checking bench for i2c_reg_bridge: directed write-burst table, read,
// latency, collision and reset sequences, plus randomized traffic against a model.
module tb_i2c_reg_bridge;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         addr_toggle = 1'b0;
    logic         rw = 1'b0;
    logic         rx_toggle = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         tx_toggle = 1'b0;
    logic [7:0]   tx_data;
    logic [8*N-1:0] regs_flat;
    logic         wr_strobe;
    logic [2:0]   wr_addr;
    logic [2:0]   ptr;

    i2c_reg_bridge #(.NUM_REGS(N), .RESET_VAL(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_toggle(addr_toggle),
        .rw         (rw),
        .rx_toggle  (rx_toggle),
        .rx_data    (rx_data),
        .tx_toggle  (tx_toggle),
        .tx_data    (tx_data),
        .regs_flat  (regs_flat),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .ptr        (ptr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference model: mode 0 idle, 1 awaiting pointer, 2 writing, 3 reading.
    logic [7:0] m_regs [N];
    int         m_ptr  = 0;
    int         m_mode = 0;
    int         exp_wr[$];
    int         act_wr[$];

    always @(negedge clk) if (wr_strobe) act_wr.push_back(int'(wr_addr));

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        m_ptr  = 0;
        m_mode = 0;
        exp_wr.delete();
        act_wr.delete();
    endtask

    task automatic model_addr(input logic r);
        m_mode = r ? 3 : 1;
    endtask

    task automatic model_rx(input logic [7:0] d);
        if (m_mode == 1) begin
            m_ptr  = int'(d) % N;
            m_mode = 2;
        end else if (m_mode == 2) begin
            m_regs[m_ptr] = d;
            exp_wr.push_back(m_ptr);
            m_ptr = (m_ptr + 1) % N;
        end
    endtask

    task automatic model_tx();
        if (m_mode == 3) m_ptr = (m_ptr + 1) % N;
    endtask

    function automatic logic [8*N-1:0] model_flat();
        logic [8*N-1:0] r;
        for (int k = 0; k < N; k++) r[8*k +: 8] = m_regs[k];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_ptr"}, 64'(ptr), 64'(m_ptr));
        check({tag, "_tx_data"}, 64'(tx_data), 64'(m_regs[m_ptr]));
        check({tag, "_regs"}, 64'(regs_flat), 64'(model_flat()));
    endtask

    task automatic check_log(input string tag);
        check({tag, "_wr_count"}, 64'(act_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++)
            check($sformatf("%s_wr_addr%0d", tag, i), 64'(act_wr[i]), 64'(exp_wr[i]));
        exp_wr.delete();
        act_wr.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_addr(input logic r, input int gap);
        @(negedge clk);
        rw = r;
        @(negedge clk);
        addr_toggle = ~addr_toggle;
        repeat (gap) @(posedge clk);
        model_addr(r);
    endtask

    task automatic send_rx(input logic [7:0] d, input int gap);
        @(negedge clk);
        rx_data   = d;
        rx_toggle = ~rx_toggle;
        repeat (gap) @(posedge clk);
        model_rx(d);
    endtask

    task automatic send_tx(input int gap);
        @(negedge clk);
        tx_toggle = ~tx_toggle;
        repeat (gap) @(posedge clk);
        model_tx();
    endtask

    typedef struct {
        logic [7:0] ptr_byte;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [2:0] exp_ptr;
        logic [2:0] a0;
        logic [7:0] v0;
        logic [2:0] a1;
        logic [7:0] v1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] reg0_before;
        int         kind;
        int         gap;

        vecs[0] = '{8'h03, 8'hAA, 8'hBB, 3'd5, 3'd3, 8'hAA, 3'd4, 8'hBB};
        vecs[1] = '{8'hFF, 8'h11, 8'h22, 3'd1, 3'd7, 8'h11, 3'd0, 8'h22};
        vecs[2] = '{8'h0A, 8'h5A, 8'hC3, 3'd4, 3'd2, 8'h5A, 3'd3, 8'hC3};
        vecs[3] = '{8'h85, 8'h01, 8'hFE, 3'd7, 3'd5, 8'h01, 3'd6, 8'hFE};

        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_regs", 64'(regs_flat), 64'h0);
        check("rst_ptr", 64'(ptr), 64'h0);
        check("rst_tx_data", 64'(tx_data), 64'h0);
        check("rst_wr_strobe", 64'(wr_strobe), 64'h0);
        check("rst_wr_addr", 64'(wr_addr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(4);

        // Data events while idle must be ignored
        send_rx(8'h44, 5);
        send_tx(5);
        settle(2);
        check("idle_ptr", 64'(ptr), 64'h0);
        check("idle_regs", 64'(regs_flat), 64'h0);
        compare_all("idle");
        check_log("idle");

        // Table-driven write bursts
        for (int v = 0; v < 4; v++) begin
            send_addr(1'b0, 5);
            send_rx(vecs[v].ptr_byte, 5);
            send_rx(vecs[v].d0, 5);
            send_rx(vecs[v].d1, 5);
            settle(2);
            check($sformatf("vec%0d_ptr", v), 64'(ptr), 64'(vecs[v].exp_ptr));
            check($sformatf("vec%0d_reg_a0", v), 64'(regs_flat[8*vecs[v].a0 +: 8]), 64'(vecs[v].v0));
            check($sformatf("vec%0d_reg_a1", v), 64'(regs_flat[8*vecs[v].a1 +: 8]), 64'(vecs[v].v1));
            check($sformatf("vec%0d_strobes", v), 64'(act_wr.size()), 64'd2);
            if (act_wr.size() >= 2) begin
                check($sformatf("vec%0d_wr_addr0", v), 64'(act_wr[0]), 64'(vecs[v].a0));
                check($sformatf("vec%0d_wr_addr1", v), 64'(act_wr[1]), 64'(vecs[v].a1));
            end
            compare_all($sformatf("vec%0d", v));
            check_log($sformatf("vec%0d", v));
        end

        // Read: point at reg2, then read phase
        send_addr(1'b0, 5);
        send_rx(8'h02, 5);
        send_addr(1'b1, 5);
        settle(2);
        check("read_ptr", 64'(ptr), 64'd2);
        check("read_tx_first", 64'(tx_data), 64'h5A);
        @(negedge clk);
        tx_toggle = ~tx_toggle;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (tx_data == 8'hC3) break;
        end
        check("read_tx_within4", 64'(tx_data), 64'hC3);
        model_tx();
        settle(3);
        compare_all("read");
        check_log("read");

        // Latency: rx toggle 1 ns before an edge lands on the 3rd edge
        send_addr(1'b0, 5);
        send_rx(8'h00, 5);
        reg0_before = m_regs[0];
        @(posedge clk);
        #9;
        rx_data   = 8'h3C;
        rx_toggle = ~rx_toggle;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_strobe_edge%0d", e), 64'(wr_strobe), 64'(e == 3));
            if (e == 2) check("lat_reg0_before", 64'(regs_flat[7:0]), 64'(reg0_before));
            if (e == 3) begin
                check("lat_reg0_after", 64'(regs_flat[7:0]), 64'h3C);
                check("lat_wr_addr", 64'(wr_addr), 64'h0);
            end
        end
        model_rx(8'h3C);
        settle(2);
        compare_all("lat");
        check_log("lat");

        // Randomized traffic, events 3..5 cycles apart
        for (int b = 0; b < 12; b++) begin
            for (int e = 0; e < 5; e++) begin
                kind = int'($urandom_range(0, 4));
                gap  = int'($urandom_range(3, 5));
                if (kind == 0) send_addr(1'($urandom_range(0, 1)), gap);
                else if (kind <= 2) send_rx(8'($urandom), gap);
                else send_tx(gap);
            end
            settle(6);
            compare_all($sformatf("rand%0d", b));
        end
        check_log("rand");

        // Collision: addr and rx events in the same cycle; addr wins
        send_addr(1'b0, 5);
        if (addr_toggle != 1'b0) send_addr(1'b0, 5);
        send_rx(8'h04, 5);
        @(negedge clk);
        rx_data     = 8'hE7;
        rx_toggle   = ~rx_toggle;
        addr_toggle = ~addr_toggle;
        repeat (6) @(posedge clk);
        model_addr(1'b0);
        #1;
        check_log("coll");
        send_rx(8'h01, 5);
        settle(2);
        check("coll_ptr", 64'(ptr), 64'd1);
        compare_all("coll");

        // Asynchronous reset while a write strobe is high
        @(negedge clk);
        rx_data   = 8'h99;
        rx_toggle = ~rx_toggle;
        repeat (3) @(posedge clk);
        #2;
        check("arst_strobe_before", 64'(wr_strobe), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_regs", 64'(regs_flat), 64'h0);
        check("arst_ptr", 64'(ptr), 64'h0);
        check("arst_tx_data", 64'(tx_data), 64'h0);
        check("arst_wr_strobe", 64'(wr_strobe), 64'h0);
        check("arst_wr_addr", 64'(wr_addr), 64'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // addr_toggle is high here, so release yields exactly one addr event
        if (addr_toggle) model_addr(rw);
        repeat (6) @(posedge clk);
        send_rx(8'h06, 5);
        send_rx(8'h77, 5);
        settle(2);
        check("post_rst_reg6", 64'(regs_flat[55:48]), 64'h77);
        check("post_rst_ptr", 64'(ptr), 64'd7);
        compare_all("post_rst");
        check_log("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
